// File: rtl/psb_pkg.sv
// Shared constants for the PHV statistics buffer.
// Config-beat field positions, command codes, register map and widths.
package psb_pkg;

  localparam int MD_W   = 256;
  localparam int PHV_W  = 1024;
  localparam int CFG_W  = 134;
  localparam int PAIR_W = MD_W + PHV_W;

  localparam int CF_HDR_HI  = 133;
  localparam int CF_HDR_LO  = 128;
  localparam int CF_VLD     = 127;
  localparam int CF_OP_HI   = 126;
  localparam int CF_OP_LO   = 124;
  localparam int CF_MID_HI  = 111;
  localparam int CF_MID_LO  = 104;
  localparam int CF_ADDR_HI = 95;
  localparam int CF_ADDR_LO = 64;
  localparam int CF_DATA_HI = 31;
  localparam int CF_DATA_LO = 0;

  localparam logic [5:0] HEAD = 6'b010000;
  localparam logic [5:0] TAIL = 6'b100000;

  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b001;

  localparam logic [31:0] REG_CTRL  = 32'd0;
  localparam logic [31:0] REG_IN    = 32'd1;
  localparam logic [31:0] REG_OUT   = 32'd2;
  localparam logic [31:0] REG_DROP  = 32'd3;
  localparam logic [31:0] REG_ERR   = 32'd4;
  localparam logic [31:0] REG_LEVEL = 32'd5;

endpackage

// File: rtl/psb_pair_fifo.sv
// Synchronous FIFO of md+phv pairs with registered read data.
// Ports: push_i/wdata_i write, pop_i loads rdata_o, level_o/full_o/empty_o status.
module psb_pair_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 1280,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [W-1:0]  rdata_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign level_o = level_q;
  assign rdata_o = rdata_q;

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q];
      end
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/phv_stat_buf.sv
// Buffers md+phv pairs from scm, forwards them under backpressure, keeps stats.
// Ports: in_psb_* from scm, out_psb_* downstream, cin/cout_psb_* config chain.
module phv_stat_buf
  import psb_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         ALF_MARGIN = 4,
  parameter logic [7:0] MODULE_ID  = 8'd124
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MD_W-1:0]   in_psb_md,
  input  logic              in_psb_md_wr,
  output logic              out_psb_md_alf,
  input  logic [PHV_W-1:0]  in_psb_phv,
  input  logic              in_psb_phv_wr,
  output logic              out_psb_phv_alf,
  output logic [MD_W-1:0]   out_psb_md,
  output logic              out_psb_md_wr,
  input  logic              in_psb_md_alf,
  output logic [PHV_W-1:0]  out_psb_phv,
  output logic              out_psb_phv_wr,
  input  logic              in_psb_phv_alf,
  input  logic [CFG_W-1:0]  cin_psb_data,
  input  logic              cin_psb_data_wr,
  output logic              cout_psb_ready,
  output logic [CFG_W-1:0]  cout_psb_data,
  output logic              cout_psb_data_wr,
  input  logic              cin_psb_ready
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] ALF_LVL = LW'(DEPTH - ALF_MARGIN);

  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [PAIR_W-1:0] rdata;

  logic              both;
  logic              push;
  logic              drop;
  logic              err;
  logic              pop;
  logic [LW-1:0]     level_d;
  logic              alf_d;

  logic              alf_q;
  logic              rvld_q;
  logic              owr_q;
  logic [MD_W-1:0]   omd_q;
  logic [PHV_W-1:0]  ophv_q;

  logic [1:0]        ctrl_q;
  logic [1:0]        ctrl_d;
  logic [31:0]       in_cnt_q;
  logic [31:0]       out_cnt_q;
  logic [31:0]       drop_cnt_q;
  logic [31:0]       err_cnt_q;
  logic              clr;

  logic              is_cmd;
  logic              rd_hit;
  logic              wr_ctrl;
  logic [2:0]        cfg_op;
  logic [31:0]       cfg_addr;
  logic [31:0]       rd_val;
  logic [CFG_W-1:0]  cfg_d;
  logic [CFG_W-1:0]  cfg_q;
  logic              cfg_wr_q;

  psb_pair_fifo #(
    .DEPTH (DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({in_psb_md, in_psb_phv}),
    .pop_i   (pop),
    .rdata_o (rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Fullness is judged before this cycle's pop, so a full FIFO drops.
  assign both    = in_psb_md_wr & in_psb_phv_wr;
  assign push    = both & ctrl_q[0] & ~full;
  assign drop    = both & ~push;
  assign err     = in_psb_md_wr ^ in_psb_phv_wr;
  assign pop     = ~empty & ~in_psb_md_alf & ~in_psb_phv_alf;
  assign level_d = level + LW'(push) - LW'(pop);
  assign alf_d   = (level_d >= ALF_LVL);
  assign clr     = ctrl_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alf_q  <= 1'b0;
      rvld_q <= 1'b0;
      owr_q  <= 1'b0;
      omd_q  <= '0;
      ophv_q <= '0;
    end else begin
      alf_q  <= alf_d;
      rvld_q <= pop;
      owr_q  <= rvld_q;
      if (rvld_q) begin
        {omd_q, ophv_q} <= rdata;
      end
    end
  end

  assign out_psb_md_alf  = alf_q;
  assign out_psb_phv_alf = alf_q;
  assign out_psb_md      = omd_q;
  assign out_psb_phv     = ophv_q;
  assign out_psb_md_wr   = owr_q;
  assign out_psb_phv_wr  = owr_q;

  assign cfg_op   = cin_psb_data[CF_OP_HI:CF_OP_LO];
  assign cfg_addr = cin_psb_data[CF_ADDR_HI:CF_ADDR_LO];
  assign is_cmd   = cin_psb_data_wr
                  & (cin_psb_data[CF_HDR_HI:CF_HDR_LO] == HEAD)
                  & cin_psb_data[CF_VLD]
                  & (cin_psb_data[CF_MID_HI:CF_MID_LO] == MODULE_ID);
  assign rd_hit   = is_cmd & (cfg_op == OP_READ);
  assign wr_ctrl  = is_cmd & (cfg_op == OP_WRITE) & (cfg_addr == REG_CTRL);

  always_comb begin
    rd_val = '0;
    case (cfg_addr)
      REG_CTRL:  rd_val = {30'd0, ctrl_q};
      REG_IN:    rd_val = in_cnt_q;
      REG_OUT:   rd_val = out_cnt_q;
      REG_DROP:  rd_val = drop_cnt_q;
      REG_ERR:   rd_val = err_cnt_q;
      REG_LEVEL: rd_val = 32'(level);
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    cfg_d = cin_psb_data;
    if (rd_hit) begin
      cfg_d[CF_DATA_HI:CF_DATA_LO] = rd_val;
    end
  end

  // Clear bit lives for one cycle; enable persists until rewritten.
  always_comb begin
    ctrl_d = {1'b0, ctrl_q[0]};
    if (wr_ctrl) begin
      ctrl_d = cin_psb_data[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      cfg_wr_q   <= 1'b0;
      ctrl_q     <= 2'b01;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      cfg_wr_q <= cin_psb_data_wr;
      if (cin_psb_data_wr) begin
        cfg_q <= cfg_d;
      end
      ctrl_q <= ctrl_d;
      if (clr) begin
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        drop_cnt_q <= '0;
        err_cnt_q  <= '0;
      end else begin
        in_cnt_q   <= in_cnt_q + 32'(push);
        out_cnt_q  <= out_cnt_q + 32'(pop);
        drop_cnt_q <= drop_cnt_q + 32'(drop);
        err_cnt_q  <= err_cnt_q + 32'(err);
      end
    end
  end

  assign cout_psb_data    = cfg_q;
  assign cout_psb_data_wr = cfg_wr_q;
  assign cout_psb_ready   = cin_psb_ready;

endmodule

// File: doc/phv_stat_buf.md
Name: phv_stat_buf

Overview:
- Stage directly downstream of scm: consumes scm's out_scm_md/out_scm_phv stream and buffers each metadata+PHV pair in a FIFO.
- Forwards pairs downstream under almost-full backpressure and keeps per-stage packet counters.
- Sits on the 134-bit configuration chain after scm. Config packets addressed to it read/write its registers; all others pass through.

Parameters:
DEPTH, 16, FIFO entries (md+phv pairs), power of two
ALF_MARGIN, 4, free entries remaining when out_psb_*_alf asserts
MODULE_ID, 8'd124, config-packet module ID this block answers to

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_psb_md  in  256  metadata from scm
in_psb_md_wr  in  1  metadata valid
out_psb_md_alf  out  1  almost-full to scm (metadata)
in_psb_phv  in  1024  PHV from scm
in_psb_phv_wr  in  1  PHV valid
out_psb_phv_alf  out  1  almost-full to scm (PHV)
out_psb_md  out  256  metadata downstream
out_psb_md_wr  out  1  metadata valid
in_psb_md_alf  in  1  downstream almost-full (metadata)
out_psb_phv  out  1024  PHV downstream
out_psb_phv_wr  out  1  PHV valid
in_psb_phv_alf  in  1  downstream almost-full (PHV)
cin_psb_data  in  134  config beat from scm
cin_psb_data_wr  in  1  config beat valid
cout_psb_ready  out  1  ready to scm (= cin_psb_ready, combinational)
cout_psb_data  out  134  config beat to next stage
cout_psb_data_wr  out  1  config beat valid
cin_psb_ready  in  1  next stage ready

Behaviour:
- Reset (rst_n low at posedge):
  - FIFO empty; all counters 0; CTRL = 32'h1 (enabled).
  - All *_wr outputs 0, data outputs 0, alf outputs 0.
  - Reset mid-operation discards buffered pairs and any in-flight config beat.
- Push:
  - in_psb_md_wr && in_psb_phv_wr in the same cycle, CTRL[0]=1, FIFO not full: store {md,phv}; IN_CNT++.
  - Only one of the two wr strobes high: nothing stored; ERR_CNT++.
  - Both high with FIFO full or CTRL[0]=0: pair dropped; DROP_CNT++.
- alf: both out_psb_*_alf registered, high when level >= DEPTH-ALF_MARGIN after the current cycle's push/pop.
- Pop:
  - When FIFO non-empty and neither in_psb_md_alf nor in_psb_phv_alf is high: pop one entry; next cycle out_psb_md/phv carry it with both wr high for exactly 1 cycle; OUT_CNT++.
  - Otherwise out wr strobes are 0 and data holds its last value.
  - Minimum latency: pair written at posedge N appears with wr high after posedge N+2.
- Simultaneous push+pop: level unchanged. Push when full is a drop even if a pop occurs that cycle.
- Counters: 32-bit, wrap 32'hFFFFFFFF -> 0. LEVEL = current occupancy (0..DEPTH).
- Config beat format:
  - [133:128] 6'b010000 head / 6'b100000 tail; [127] valid; [126:124] opcode (3'b010 write, 3'b001 read); [123:112] reserved.
  - [111:104] module ID; [103:96] stage ID; [95:64] reg address; [63:32] reserved; [31:0] data.
  - Only head beats carry commands.
- Config path:
  - Every beat with cin_psb_data_wr is registered and emitted on cout_psb_data/cout_psb_data_wr one cycle later.
  - For a head beat with valid=1 and module ID == MODULE_ID:
    - Write: register updated at that posedge; beat forwarded unchanged.
    - Read: forwarded beat has [31:0] replaced by register value.
  - Unknown address reads return 0; writes to read-only or unknown addresses are ignored.
- Registers:
  - 0 CTRL: bit0 enable; bit1 clear counters, self-clears next cycle.
  - 1 IN_CNT, 2 OUT_CNT, 3 DROP_CNT, 4 ERR_CNT, 5 LEVEL, all read-only.
- Clear vs increment in the same cycle: clear wins (counter = 0).

Decomposition:
- Package psb_pkg holds:
  - config field bit positions, HEAD/TAIL codes, OP_READ/OP_WRITE;
  - register address constants;
  - width constants MD_W=256, PHV_W=1024, CFG_W=134.
- Sub-module psb_pair_fifo: synchronous 1280-bit FIFO with level output, full/empty and registered read data.

Test Plan:
- Single pair: md=256'h1, phv=1024'hEEE1 with both wr -> out wr high exactly one cycle, 2 cycles later, data identical; IN_CNT=OUT_CNT=1.
- Backpressure: hold in_psb_md_alf=1, push 12 pairs -> out_psb_md_alf=1 after 12th; push 5 more -> 4 stored, DROP_CNT=1; release alf -> 16 pairs out in order on consecutive cycles.
- Mismatch: in_psb_md_wr=1, in_psb_phv_wr=0 -> nothing output; ERR_CNT=1.
- Config read: head {6'b010000,1,3'b001,12'b0,8'd124,8'd7,32'h1,32'b0,32'b0} after 3 pairs -> forwarded beat next cycle with [31:0]=32'h3. Same beat with module ID 123 -> forwarded unchanged.
- Config write CTRL=0, push a pair -> dropped, DROP_CNT++. Then write CTRL=32'h2 -> all counters read 0, CTRL reads 0.
- Reset mid-operation: 5 pairs buffered, pulse rst_n low one cycle -> no output wr afterwards, LEVEL=0, alf=0, CTRL=1.
